mii_mgmt_responder: RTL and testbench

//  PHY-side Clause-22 MDIO management target: the responder end of the MDC/MDIO link driven by the MAC's management initiator.

---
 rtl/mii_mgmt_responder.sv | 202 ++++++++++++++++++++
 tb/tb_mii_mgmt_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mii_mgmt_responder.sv
// ============================================================================
// mii_mgmt_responder : Clause-22 MDIO management target with a 32x16 regfile
// Rev 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mii_mgmt_responder #(
  parameter logic [4:0] PHY_ADDR     = 5'd1,
  parameter int         MIN_PREAMBLE = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oe,
  input  logic [4:0]  lcl_addr,
  input  logic        lcl_we,
  input  logic [15:0] lcl_wdata,
  output logic [15:0] lcl_rdata,
  output logic        wr_stb,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        busy
);

  localparam int            PW      = (MIN_PREAMBLE < 1) ? 1 : $clog2(MIN_PREAMBLE + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(MIN_PREAMBLE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ST2   = 3'd1,
    S_OP    = 3'd2,
    S_PHYAD = 3'd3,
    S_REGAD = 3'd4,
    S_TA    = 3'd5,
    S_DATA  = 3'd6,
    S_ABORT = 3'd7
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_mdc_s1, r_mdc_s2, r_mdc_d;
  logic          r_mdio_s1, r_mdio_s2;
  logic [PW-1:0] r_pre_cnt;
  logic [3:0]    r_bit_cnt;
  logic          r_op_hi;
  logic          r_is_read;
  logic [4:0]    r_phyad;
  logic [4:0]    r_regad;
  logic [15:0]   r_shift;
  logic          r_mdio_out;
  logic          r_mdio_oe;
  logic [15:0]   r_mem [32];
  logic [15:0]   r_lcl_rdata;
  logic          r_wr_stb;
  logic [4:0]    r_wr_addr;
  logic [15:0]   r_wr_data;

  logic          w_edge;
  logic          w_bit;
  logic          w_match;
  logic          w_drive;
  logic          w_commit;
  logic [15:0]   w_cdata;

  // MDIO rides the same synchroniser depth as MDC so the sampled bit lines up with the edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mdc_s1  <= 1'b0;
      r_mdc_s2  <= 1'b0;
      r_mdc_d   <= 1'b0;
      r_mdio_s1 <= 1'b0;
      r_mdio_s2 <= 1'b0;
    end else begin
      r_mdc_s1  <= mdc;
      r_mdc_s2  <= r_mdc_s1;
      r_mdc_d   <= r_mdc_s2;
      r_mdio_s1 <= mdio_in;
      r_mdio_s2 <= r_mdio_s1;
    end
  end

  assign w_edge   = r_mdc_s2 & ~r_mdc_d;
  assign w_bit    = r_mdio_s2;
  assign w_match  = (r_phyad == PHY_ADDR);
  assign w_drive  = r_is_read & w_match;
  assign w_commit = w_edge && (r_state == S_DATA) && (r_bit_cnt == 4'd15) && !r_is_read && w_match;
  assign w_cdata  = {r_shift[14:0], w_bit};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_edge && !w_bit && (r_pre_cnt >= PRE_MAX)) w_state_nxt = S_ST2;
      S_ST2:   if (w_edge) w_state_nxt = w_bit ? S_OP : S_ABORT;
      S_OP:    if (w_edge && (r_bit_cnt == 4'd1))
                 w_state_nxt = (r_op_hi != w_bit) ? S_PHYAD : S_ABORT;
      S_PHYAD: if (w_edge && (r_bit_cnt == 4'd4)) w_state_nxt = S_REGAD;
      S_REGAD: if (w_edge && (r_bit_cnt == 4'd4)) w_state_nxt = S_TA;
      S_TA:    if (w_edge && (r_bit_cnt == 4'd1)) w_state_nxt = S_DATA;
      S_DATA:  if (w_edge && (r_bit_cnt == 4'd15)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_op_hi    <= 1'b0;
      r_is_read  <= 1'b0;
      r_phyad    <= '0;
      r_regad    <= '0;
      r_shift    <= '0;
      r_mdio_out <= 1'b0;
      r_mdio_oe  <= 1'b0;
    end else if (r_state == S_ABORT) begin
      r_pre_cnt <= '0;
    end else if (w_edge) begin
      r_bit_cnt <= (w_state_nxt != r_state) ? 4'd0 : r_bit_cnt + 4'd1;
      case (r_state)
        S_IDLE: begin
          if (w_bit && (r_pre_cnt != PRE_MAX)) r_pre_cnt <= r_pre_cnt + 1'b1;
          else if (!w_bit)                     r_pre_cnt <= '0;
        end
        S_OP: begin
          if (r_bit_cnt == 4'd0) r_op_hi   <= w_bit;
          else                   r_is_read <= r_op_hi & ~w_bit;
        end
        S_PHYAD: r_phyad <= {r_phyad[3:0], w_bit};
        S_REGAD: r_regad <= {r_regad[3:0], w_bit};
        S_TA: begin
          if (w_drive && (r_bit_cnt == 4'd0)) begin
            r_shift    <= r_mem[r_regad];
            r_mdio_oe  <= 1'b1;
            r_mdio_out <= 1'b0;
          end else if (w_drive) begin
            r_mdio_out <= r_shift[15];
            r_shift    <= {r_shift[14:0], 1'b0};
          end
        end
        S_DATA: begin
          if (!r_is_read) begin
            r_shift <= w_cdata;
          end else if (w_drive && (r_bit_cnt == 4'd15)) begin
            r_mdio_oe  <= 1'b0;
            r_mdio_out <= 1'b0;
          end else if (w_drive) begin
            r_mdio_out <= r_shift[15];
            r_shift    <= {r_shift[14:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  // A local write to the same address in the commit cycle overrides the MDIO data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (lcl_we && (lcl_addr == 5'(i)))        r_mem[i] <= lcl_wdata;
        else if (w_commit && (r_regad == 5'(i)))  r_mem[i] <= w_cdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lcl_rdata <= '0;
      r_wr_stb    <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_lcl_rdata <= r_mem[lcl_addr];
      r_wr_stb    <= w_commit;
      if (w_commit) begin
        r_wr_addr <= r_regad;
        r_wr_data <= w_cdata;
      end
    end
  end

  assign mdio_out  = r_mdio_out;
  assign mdio_oe   = r_mdio_oe;
  assign lcl_rdata = r_lcl_rdata;
  assign wr_stb    = r_wr_stb;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign busy      = (r_state != S_IDLE) && (r_state != S_ABORT);

endmodule

`default_nettype wire

// File: tb/tb_mii_mgmt_responder.sv
// ============================================================================
// tb_mii_mgmt_responder : directed bench for the MDIO management target
// Rev 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mii_mgmt_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mdc = 1'b0;
  logic        mdio_in = 1'b1;
  logic [4:0]  lcl_addr = 5'd0;
  logic        lcl_we = 1'b0;
  logic [15:0] lcl_wdata = 16'h0;

  logic        mdio_out, mdio_oe, wr_stb, busy;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data, lcl_rdata;
  logic        mdio_out0, mdio_oe0, wr_stb0, busy0;
  logic [4:0]  wr_addr0;
  logic [15:0] wr_data0, lcl_rdata0;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int wr_cnt0 = 0;
  bit oe_seen = 1'b0;
  bit busy_seen = 1'b0;

  logic [18:0] oe_pat, out_pat;
  logic [15:0] rd_data;
  int          base, base0;
  logic        pre_oe, got;

  mii_mgmt_responder #(.PHY_ADDR(5'd1), .MIN_PREAMBLE(32)) u_dut (
    .clk(clk), .reset_n(reset_n), .mdc(mdc), .mdio_in(mdio_in),
    .mdio_out(mdio_out), .mdio_oe(mdio_oe),
    .lcl_addr(lcl_addr), .lcl_we(lcl_we), .lcl_wdata(lcl_wdata), .lcl_rdata(lcl_rdata),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  mii_mgmt_responder #(.PHY_ADDR(5'd1), .MIN_PREAMBLE(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .mdc(mdc), .mdio_in(mdio_in),
    .mdio_out(mdio_out0), .mdio_oe(mdio_oe0),
    .lcl_addr(lcl_addr), .lcl_we(lcl_we), .lcl_wdata(lcl_wdata), .lcl_rdata(lcl_rdata0),
    .wr_stb(wr_stb0), .wr_addr(wr_addr0), .wr_data(wr_data0), .busy(busy0)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb)  wr_cnt  <= wr_cnt + 1;
    if (wr_stb0) wr_cnt0 <= wr_cnt0 + 1;
    if (mdio_oe) oe_seen <= 1'b1;
    if (busy)    busy_seen <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mdc_bit(input logic b);
    mdc = 1'b0; mdio_in = b; #80;
    mdc = 1'b1; #80;
  endtask

  task automatic send_ones(input int n);
    for (int i = 0; i < n; i++) mdc_bit(1'b1);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) mdc_bit(v[i]);
  endtask

  task automatic write_frame(input int pre, input logic [4:0] phy, input logic [4:0] ra,
                             input logic [15:0] d);
    send_ones(pre);
    send_bits({2'b01, 2'b01, phy, ra, 2'b10, d}, 32);
  endtask

  // Pattern index j holds the bus state after the j-th edge following REGAD
  task automatic read_frame(input logic [4:0] phy, input logic [4:0] ra);
    send_ones(32);
    send_bits(32'({2'b01, 2'b10, phy, ra}), 14);
    for (int j = 0; j < 19; j++) begin
      mdc = 1'b0; mdio_in = 1'b1; #78;
      oe_pat[j] = mdio_oe; out_pat[j] = mdio_out; #2;
      mdc = 1'b1; #80;
    end
    rd_data = '0;
    for (int j = 2; j < 18; j++) rd_data = {rd_data[14:0], out_pat[j]};
  endtask

  task automatic lcl_read(input logic [4:0] a);
    lcl_addr = a;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #22;
    check("rst_ctrl", 32'({mdio_oe, mdio_out, wr_stb, busy}), 32'd0);
    check("rst_wr", 32'({wr_addr, wr_data}), 32'd0);
    check("rst_rdata", 32'(lcl_rdata), 32'd0);
    #8 reset_n = 1'b1;
    #20;

    // Basic write
    base = wr_cnt; busy_seen = 1'b0;
    write_frame(32, 5'd1, 5'd4, 16'hBEEF);
    check("wr_stb_cnt", 32'(wr_cnt - base), 32'd1);
    check("wr_addr", 32'(wr_addr), 32'd4);
    check("wr_data", 32'(wr_data), 32'hBEEF);
    check("wr_busy", 32'(busy_seen), 32'd1);
    lcl_read(5'd4);
    check("wr_lcl_rdata", 32'(lcl_rdata), 32'hBEEF);

    // 31-one preamble is too short
    base = wr_cnt; busy_seen = 1'b0;
    write_frame(31, 5'd1, 5'd4, 16'h1111);
    check("pre31_stb", 32'(wr_cnt - base), 32'd0);
    check("pre31_busy", 32'(busy_seen), 32'd0);
    lcl_read(5'd4);
    check("pre31_reg", 32'(lcl_rdata), 32'hBEEF);

    base = wr_cnt;
    write_frame(32, 5'd1, 5'd9, 16'h5555);
    check("pre32_stb", 32'(wr_cnt - base), 32'd1);
    check("pre32_wr", 32'({wr_addr, wr_data}), 32'({5'd9, 16'h5555}));

    // Read back BEEF
    read_frame(5'd1, 5'd4);
    check("rd_oe_pat", 32'(oe_pat), 32'h3FFFE);
    check("rd_ta_zero", 32'(out_pat[1]), 32'd0);
    check("rd_data", 32'(rd_data), 32'hBEEF);
    check("rd_busy_end", 32'(busy), 32'd0);

    // Foreign PHY address
    base = wr_cnt; oe_seen = 1'b0; busy_seen = 1'b0;
    write_frame(32, 5'd2, 5'd4, 16'hDEAD);
    read_frame(5'd2, 5'd4);
    check("phy2_stb", 32'(wr_cnt - base), 32'd0);
    check("phy2_oe", 32'(oe_seen), 32'd0);
    check("phy2_busy", 32'(busy_seen), 32'd1);
    lcl_read(5'd4);
    check("phy2_reg", 32'(lcl_rdata), 32'hBEEF);

    // OP=11 aborts; the next preamble-less frame is ignored
    oe_seen = 1'b0; busy_seen = 1'b0;
    send_ones(32);
    send_bits(32'h7, 4);
    check("abort_busy_seen", 32'(busy_seen), 32'd1);
    check("abort_busy_now", 32'(busy), 32'd0);
    base = wr_cnt; busy_seen = 1'b0;
    write_frame(0, 5'd1, 5'd10, 16'h7777);
    check("abort_next_stb", 32'(wr_cnt - base), 32'd0);
    check("abort_next_busy", 32'(busy_seen), 32'd0);
    check("abort_oe", 32'(oe_seen), 32'd0);

    // Preamble suppression instance takes back-to-back frames
    base = wr_cnt; base0 = wr_cnt0;
    write_frame(0, 5'd1, 5'd11, 16'h0F0F);
    write_frame(0, 5'd1, 5'd12, 16'hF0F0);
    check("np_stb0", 32'(wr_cnt0 - base0), 32'd2);
    check("np_wr0", 32'({wr_addr0, wr_data0}), 32'({5'd12, 16'hF0F0}));
    check("np_stb32", 32'(wr_cnt - base), 32'd0);
    lcl_read(5'd11);
    check("np_reg11", 32'(lcl_rdata0), 32'h0F0F);

    // Local write collides with the MDIO commit
    base = wr_cnt;
    send_ones(32);
    send_bits({2'b01, 2'b01, 5'd1, 5'd7, 2'b10, 15'(16'hAAAA >> 1)}, 31);
    mdc = 1'b0; mdio_in = 1'b0; #80;
    mdc = 1'b1; lcl_addr = 5'd7; lcl_wdata = 16'h1234; lcl_we = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if (wr_stb) got = 1'b1;
    end
    lcl_we = 1'b0;
    #50;
    check("coll_stb_seen", 32'(got), 32'd1);
    check("coll_stb_cnt", 32'(wr_cnt - base), 32'd1);
    check("coll_wr", 32'({wr_addr, wr_data}), 32'({5'd7, 16'hAAAA}));
    lcl_read(5'd7);
    check("coll_reg", 32'(lcl_rdata), 32'h1234);

    // Reset in the middle of read data
    send_ones(32);
    send_bits(32'({2'b01, 2'b10, 5'd1, 5'd4}), 14);
    for (int j = 0; j < 9; j++) begin
      mdc = 1'b0; mdio_in = 1'b1; #80;
      mdc = 1'b1; #80;
    end
    mdc = 1'b0; #40;
    pre_oe = mdio_oe;
    reset_n = 1'b0; #1;
    check("mid_pre_oe", 32'(pre_oe), 32'd1);
    check("mid_rst_oe", 32'(mdio_oe), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    #39 reset_n = 1'b1;
    lcl_read(5'd4);
    check("mid_rst_reg", 32'(lcl_rdata), 32'd0);
    base = wr_cnt;
    write_frame(32, 5'd1, 5'd3, 16'h0102);
    check("mid_after_stb", 32'(wr_cnt - base), 32'd1);
    check("mid_after_wr", 32'({wr_addr, wr_data}), 32'({5'd3, 16'h0102}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
